// File: rtl/jof32_pkg.sv
// Shared decode constants for the decode/redirect stage: opcodes, fetch
// PC-select encodings, the redirect FSM states and the branch-offset
// sign-extension helper.
package jof32_pkg;

    localparam logic [5:0] OP_JMP = 6'h02;
    localparam logic [5:0] OP_BR  = 6'h04;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_JUMP   = 2'b01;
    localparam logic [1:0] SEL_BRANCH = 2'b10;

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_WAIT_COND = 1'b1
    } state_e;

    // Widen the 10-bit branch offset to 32 bits, keeping its sign.
    function automatic logic [31:0] sext_offset(input logic [9:0] off);
        return {{22{off[9]}}, off};
    endfunction

endpackage

// File: rtl/decode_redirect_target.sv
// Pure combinational target generation for the decode stage: the
// sequential (replay / not-taken) PC and the taken-branch PC.
// Both wrap modulo the PC width.
module redirect_target
    import jof32_pkg::*;
#(
    parameter int SIZE_PC = 9
) (
    input  logic [SIZE_PC:0] pc_i,
    input  logic [9:0]       offset_i,
    output logic [SIZE_PC:0] seq_o,
    output logic [SIZE_PC:0] target_o
);

    localparam int PW = SIZE_PC + 1;

    logic [31:0] offExt;

    assign offExt   = sext_offset(offset_i);
    assign seq_o    = pc_i + PW'(1);
    assign target_o = PW'(32'(pc_i) + offExt);

endmodule

// File: rtl/decode_redirect.sv
// Decode-stage register plus fetch redirect control. Jumps redirect in
// the decode cycle; branches park in WAIT_COND replaying pc_id+1 until
// execute resolves the condition or the wait times out. Every advancing
// redirect squashes the ID slot for exactly one bubble.
module decode_redirect
    import jof32_pkg::*;
#(
    parameter int SIZE_PC      = 9,
    parameter int COND_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       inst_in,
    input  logic [SIZE_PC:0]  pc_in,
    input  logic              stall_in,
    input  logic              cond_valid,
    input  logic              cond_taken,
    output logic [31:0]       inst_id,
    output logic [SIZE_PC:0]  pc_id,
    output logic              valid_id,
    output logic [SIZE_PC:0]  pc_jump,
    output logic [SIZE_PC:0]  pc_branch,
    output logic [1:0]        sel_dir,
    output logic              flag_branch,
    output logic              err_timeout
);

    localparam int CNT_W = (COND_TIMEOUT < 1) ? 1 : $clog2(COND_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        inst_q, inst_d;
    logic [SIZE_PC:0]   pc_q, pc_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic [1:0]         selC;
    logic [SIZE_PC:0]   jumpC;
    logic [SIZE_PC:0]   branchC;
    logic [SIZE_PC:0]   seqPc;
    logic [SIZE_PC:0]   takenPc;
    logic [5:0]         opcode;
    logic               squash;

    assign opcode = inst_q[31:26];

    redirect_target #(
        .SIZE_PC (SIZE_PC)
    ) u_target (
        .pc_i     (pc_q),
        .offset_i (inst_q[9:0]),
        .seq_o    (seqPc),
        .target_o (takenPc)
    );

    // Next-state, ID-register update and redirect outputs for both states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        err_d   = err_q;
        selC    = SEL_SEQ;
        jumpC   = '0;
        branchC = '0;
        squash  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (stall_in) begin
                    selC    = SEL_BRANCH;
                    branchC = seqPc;
                end else if (valid_q && opcode == OP_JMP) begin
                    selC   = SEL_JUMP;
                    jumpC  = inst_q[SIZE_PC:0];
                    squash = 1'b1;
                end else if (valid_q && opcode == OP_BR) begin
                    state_d = ST_WAIT_COND;
                    cnt_d   = '0;
                end else begin
                    inst_d  = inst_in;
                    pc_d    = pc_in;
                    valid_d = 1'b1;
                end
            end
            ST_WAIT_COND: begin
                selC = SEL_BRANCH;
                if (cond_valid) begin
                    branchC = cond_taken ? takenPc : seqPc;
                    squash  = 1'b1;
                    state_d = ST_RUN;
                end else if (cnt_q == CNT_W'(COND_TIMEOUT)) begin
                    branchC = seqPc;
                    err_d   = 1'b1;
                    squash  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    branchC = seqPc;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (squash) begin
            inst_d  = '0;
            valid_d = 1'b0;
            pc_d    = pc_in;
        end
    end

    // State, wait counter, ID slot and sticky timeout flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            inst_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Redirect outputs are forced quiet while reset is held, so a stall
    // during reset cannot produce a replay request.
    assign sel_dir     = rst_n ? selC    : SEL_SEQ;
    assign pc_jump     = rst_n ? jumpC   : '0;
    assign pc_branch   = rst_n ? branchC : '0;
    assign flag_branch = (sel_dir == SEL_BRANCH);

    assign inst_id     = inst_q;
    assign pc_id       = pc_q;
    assign valid_id    = valid_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_decode_redirect.sv
// Directed, table-driven bench for decode_redirect: straight-line flow,
// jump, late taken branch, stall replay, wrap-around not-taken branch,
// condition timeout and reset in the middle of a branch wait.
module tb_decode_redirect;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_in;
    logic [9:0]  pc_in;
    logic        stall_in;
    logic        cond_valid;
    logic        cond_taken;
    logic [31:0] inst_id;
    logic [9:0]  pc_id;
    logic        valid_id;
    logic [9:0]  pc_jump;
    logic [9:0]  pc_branch;
    logic [1:0]  sel_dir;
    logic        flag_branch;
    logic        err_timeout;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [9:0]  pc;
        logic        stall;
        logic        cv;
        logic        ct;
        logic [31:0] eInst;
        logic [9:0]  ePc;
        logic        eValid;
        logic [1:0]  eSel;
        logic [9:0]  eJump;
        logic [9:0]  eBranch;
        logic        eErr;
    } vec_t;

    vec_t vecs[$];

    decode_redirect #(
        .SIZE_PC      (9),
        .COND_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_in     (inst_in),
        .pc_in       (pc_in),
        .stall_in    (stall_in),
        .cond_valid  (cond_valid),
        .cond_taken  (cond_taken),
        .inst_id     (inst_id),
        .pc_id       (pc_id),
        .valid_id    (valid_id),
        .pc_jump     (pc_jump),
        .pc_branch   (pc_branch),
        .sel_dir     (sel_dir),
        .flag_branch (flag_branch),
        .err_timeout (err_timeout)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(string name, logic [31:0] inst, logic [9:0] pc,
                                   logic stall, logic cv, logic ct,
                                   logic [31:0] eInst, logic [9:0] ePc, logic eValid,
                                   logic [1:0] eSel, logic [9:0] eJump,
                                   logic [9:0] eBranch, logic eErr);
        vec_t v;
        v.name = name; v.inst = inst; v.pc = pc; v.stall = stall; v.cv = cv; v.ct = ct;
        v.eInst = eInst; v.ePc = ePc; v.eValid = eValid; v.eSel = eSel;
        v.eJump = eJump; v.eBranch = eBranch; v.eErr = eErr;
        return v;
    endfunction

    task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        inst_in    = v.inst;
        pc_in      = v.pc;
        stall_in   = v.stall;
        cond_valid = v.cv;
        cond_taken = v.ct;
    endtask

    task automatic checkOutput(vec_t v);
        checkVal({v.name, ".inst_id"},  inst_id, v.eInst);
        if (v.eValid)
            checkVal({v.name, ".pc_id"}, 32'(pc_id), 32'(v.ePc));
        checkVal({v.name, ".valid_id"}, 32'(valid_id), 32'(v.eValid));
        checkVal({v.name, ".sel_dir"},  32'(sel_dir), 32'(v.eSel));
        checkVal({v.name, ".pc_jump"},  32'(pc_jump), 32'(v.eJump));
        checkVal({v.name, ".pc_branch"}, 32'(pc_branch), 32'(v.eBranch));
        checkVal({v.name, ".flag_branch"}, 32'(flag_branch), 32'(v.eSel == 2'b10));
        checkVal({v.name, ".err_timeout"}, 32'(err_timeout), 32'(v.eErr));
    endtask

    // Called just after a rising edge: drive the row, check mid-cycle, advance.
    task automatic stepCheck(vec_t v);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v);
        @(posedge clk);
        #1;
    endtask

    task automatic checkZero(string name);
        checkVal({name, ".inst_id"},     inst_id, 32'h0);
        checkVal({name, ".pc_id"},       32'(pc_id), 32'h0);
        checkVal({name, ".valid_id"},    32'(valid_id), 32'h0);
        checkVal({name, ".sel_dir"},     32'(sel_dir), 32'h0);
        checkVal({name, ".pc_jump"},     32'(pc_jump), 32'h0);
        checkVal({name, ".pc_branch"},   32'(pc_branch), 32'h0);
        checkVal({name, ".flag_branch"}, 32'(flag_branch), 32'h0);
        checkVal({name, ".err_timeout"}, 32'(err_timeout), 32'h0);
    endtask

    localparam logic [31:0] JMP1 = 32'h0800_0123;
    localparam logic [31:0] JMP2 = 32'h0800_0055;
    localparam logic [31:0] BRT  = 32'h1000_03FE;
    localparam logic [31:0] BRN  = 32'h1000_0005;
    localparam logic [31:0] BRW  = 32'h1000_0010;

    initial begin
        vec_t v;

        // Straight line, then jump
        vecs.push_back(mkVec("seq0", 32'h0000_1110, 10'h010, 0,0,0, 32'h0, 10'h000, 0, 2'b00, 10'h0, 10'h0, 0));
        vecs.push_back(mkVec("seq1", 32'h0000_1111, 10'h011, 0,0,0, 32'h0000_1110, 10'h010, 1, 2'b00, 10'h0, 10'h0, 0));
        vecs.push_back(mkVec("seq2", 32'h0000_1112, 10'h012, 0,0,0, 32'h0000_1111, 10'h011, 1, 2'b00, 10'h0, 10'h0, 0));
        vecs.push_back(mkVec("seq3", 32'h0000_1113, 10'h013, 0,0,0, 32'h0000_1112, 10'h012, 1, 2'b00, 10'h0, 10'h0, 0));
        vecs.push_back(mkVec("seq4", JMP1,          10'h020, 0,0,0, 32'h0000_1113, 10'h013, 1, 2'b00, 10'h0, 10'h0, 0));
        vecs.push_back(mkVec("jmp",  32'h0000_0AAA, 10'h021, 0,0,0, JMP1, 10'h020, 1, 2'b01, 10'h123, 10'h0, 0));
        vecs.push_back(mkVec("jmpBubble", 32'h0000_5123, 10'h123, 0,0,0, 32'h0, 10'h000, 0, 2'b00, 10'h0, 10'h0, 0));
        vecs.push_back(mkVec("jmpTarget", BRT, 10'h040, 0,0,0, 32'h0000_5123, 10'h123, 1, 2'b00, 10'h0, 10'h0, 0));
        // Late taken branch with offset -2
        vecs.push_back(mkVec("brDecide", 32'h0000_0777, 10'h041, 0,0,0, BRT, 10'h040, 1, 2'b00, 10'h0, 10'h0, 0));
        vecs.push_back(mkVec("brReplay0", 32'h0000_0777, 10'h041, 0,0,0, BRT, 10'h040, 1, 2'b10, 10'h0, 10'h041, 0));
        vecs.push_back(mkVec("brReplay1", 32'h0000_0777, 10'h041, 0,0,0, BRT, 10'h040, 1, 2'b10, 10'h0, 10'h041, 0));
        vecs.push_back(mkVec("brReplay2", 32'h0000_0777, 10'h041, 0,0,0, BRT, 10'h040, 1, 2'b10, 10'h0, 10'h041, 0));
        vecs.push_back(mkVec("brTaken", 32'h0000_0778, 10'h042, 0,1,1, BRT, 10'h040, 1, 2'b10, 10'h0, 10'h03E, 0));
        vecs.push_back(mkVec("brBubble", 32'h0000_003E, 10'h03E, 0,0,0, 32'h0, 10'h000, 0, 2'b00, 10'h0, 10'h0, 0));
        // Stall in RUN suppresses a decoded jump and ignores cond_valid
        vecs.push_back(mkVec("stallPre", JMP2, 10'h03F, 0,0,0, 32'h0000_003E, 10'h03E, 1, 2'b00, 10'h0, 10'h0, 0));
        vecs.push_back(mkVec("stallJmp", 32'h0000_0BBB, 10'h040, 1,1,1, JMP2, 10'h03F, 1, 2'b10, 10'h0, 10'h040, 0));
        vecs.push_back(mkVec("stallRel", 32'h0000_0BBB, 10'h040, 0,0,0, JMP2, 10'h03F, 1, 2'b01, 10'h055, 10'h0, 0));
        vecs.push_back(mkVec("jmp2Bubble", BRN, 10'h3FF, 0,0,0, 32'h0, 10'h000, 0, 2'b00, 10'h0, 10'h0, 0));
        // Not-taken branch at the top of the PC space wraps to zero
        vecs.push_back(mkVec("wrapDecide", 32'h0000_0000, 10'h000, 0,0,0, BRN, 10'h3FF, 1, 2'b00, 10'h0, 10'h0, 0));
        vecs.push_back(mkVec("wrapNotTaken", 32'h0000_0000, 10'h000, 1,1,0, BRN, 10'h3FF, 1, 2'b10, 10'h0, 10'h000, 0));
        vecs.push_back(mkVec("wrapBubble", 32'h0000_0002, 10'h001, 0,0,0, 32'h0, 10'h000, 0, 2'b00, 10'h0, 10'h0, 0));
        vecs.push_back(mkVec("wrapAfter", BRW, 10'h100, 0,0,0, 32'h0000_0002, 10'h001, 1, 2'b00, 10'h0, 10'h0, 0));

        rst_n = 1'b0;
        inst_in = 32'h0; pc_in = 10'h0;
        stall_in = 1'b1; cond_valid = 1'b1; cond_taken = 1'b1;
        #3;
        checkZero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            stepCheck(vecs[i]);

        // Timeout: condition never arrives
        stepCheck(mkVec("toDecide", 32'h0000_0003, 10'h101, 0,0,0, BRW, 10'h100, 1, 2'b00, 10'h0, 10'h0, 0));
        for (int k = 0; k < 15; k++)
            stepCheck(mkVec($sformatf("toWait%0d", k), 32'h0000_0003, 10'h101, 0,0,0,
                            BRW, 10'h100, 1, 2'b10, 10'h0, 10'h101, 0));
        stepCheck(mkVec("toExpire", 32'h0000_0004, 10'h101, 0,0,0, BRW, 10'h100, 1, 2'b10, 10'h0, 10'h101, 0));
        stepCheck(mkVec("toBubble", BRW, 10'h200, 0,0,0, 32'h0, 10'h000, 0, 2'b00, 10'h0, 10'h0, 1));
        stepCheck(mkVec("toSticky", 32'h0000_0005, 10'h201, 0,0,0, BRW, 10'h200, 1, 2'b00, 10'h0, 10'h0, 1));
        stepCheck(mkVec("rstWait0", 32'h0000_0005, 10'h201, 0,0,0, BRW, 10'h200, 1, 2'b10, 10'h0, 10'h201, 1));

        // Reset asserted mid-wait, with stall and cond_valid both high
        stall_in = 1'b1; cond_valid = 1'b1; cond_taken = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkZero("midReset");
        @(negedge clk);
        v = mkVec("postReset", 32'h0000_0777, 10'h300, 0,0,0, 32'h0, 10'h0, 0, 2'b00, 10'h0, 10'h0, 0);
        applyStimulus(v);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        stepCheck(mkVec("postReset", 32'h0000_0888, 10'h301, 0,0,0, 32'h0000_0777, 10'h300, 1, 2'b00, 10'h0, 10'h0, 0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/decode_redirect.md
DECODE_REDIRECT -- requirements
Module: decode_redirect

Interface
REQ-001 SHALL have parameter SIZE_PC, default 9, meaning PC MSB index (PC width = SIZE_PC+1).
REQ-002 SHALL have parameter COND_TIMEOUT, default 15, meaning max cycles WAIT_COND waits for a condition.
REQ-003 SHALL have ports clk and rst_n; one clock; reset is asynchronous and active-low.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- inst_in  in  32  instruction from fetch
- pc_in  in  SIZE_PC+1  PC of inst_in
- stall_in  in  1  hazard stall request
- cond_valid  in  1  execute-stage condition valid
- cond_taken  in  1  branch taken; qualified by cond_valid
- inst_id  out  32  registered ID instruction
- pc_id  out  SIZE_PC+1  registered ID PC
- valid_id  out  1  inst_id is live
- pc_jump  out  SIZE_PC+1  jump target to fetch
- pc_branch  out  SIZE_PC+1  branch/replay target to fetch
- sel_dir  out  2  fetch PC select: 00 sequential, 01 jump, 10 branch
- flag_branch  out  1  branch enable to fetch
- err_timeout  out  1  sticky condition-timeout flag

Function
REQ-005 SHALL decode opcode = inst_id[31:26]: OP_JMP = 6'h02, OP_BR = 6'h04; any other opcode is sequential.
REQ-006 SHALL implement states RUN and WAIT_COND.
REQ-007 RUN, stall_in=0, valid_id=1, OP_JMP: SHALL drive sel_dir=01 and pc_jump=inst_id[SIZE_PC:0] combinationally in that cycle.
REQ-008 RUN, stall_in=0, valid_id=1, OP_BR: SHALL go to WAIT_COND at next edge, clear the wait counter, and hold inst_id/pc_id.
REQ-009 In WAIT_COND, cond_valid=0: SHALL drive the replay redirect (sel_dir=10, pc_branch=pc_id+1) and increment the counter.
REQ-010 In WAIT_COND, cond_valid=1: SHALL drive sel_dir=10 with pc_branch = pc_id + sign-extended inst_id[9:0] if cond_taken, else pc_id+1, then return to RUN.
REQ-011 In WAIT_COND, counter = COND_TIMEOUT with cond_valid=0: SHALL resolve as not-taken, set err_timeout, and return to RUN.
REQ-012 RUN, stall_in=1: SHALL hold inst_id/pc_id/valid_id, drive the replay redirect, and suppress jump decode.
REQ-013 Otherwise SHALL drive sel_dir=00 with pc_jump and pc_branch at 0.
REQ-014 flag_branch SHALL equal (sel_dir==10) in every cycle.
REQ-015 Squash: in any cycle driving sel_dir≠00 that advances ID, the next edge SHALL load inst_id=0 and valid_id=0, giving exactly one bubble.
- Advancing cycles: jump, resolution, timeout.
- Replay cycles hold ID instead.
REQ-016 Normal advance (sel_dir=00, stall_in=0): the edge SHALL load inst_in, pc_in and set valid_id=1.
REQ-017 All PC arithmetic SHALL be modulo 2^(SIZE_PC+1); wrap at 0x3FF+1 gives 0x000.
REQ-018 cond_valid SHALL be ignored outside WAIT_COND; in WAIT_COND it SHALL win over stall_in.
REQ-019 Redirect latency SHALL be 0 cycles (combinational in the decision cycle).
- Target instruction reaches inst_id 2 edges later.

Reset
REQ-020 While rst_n=0: state=RUN, counter=0, inst_id=0, pc_id=0, valid_id=0, err_timeout=0, sel_dir=00, flag_branch=0, pc_jump=0, pc_branch=0.
REQ-021 Reset asserted mid-WAIT_COND SHALL abandon the branch with no redirect; the first post-reset edge loads inst_in normally.
REQ-022 err_timeout SHALL clear only on reset.

Structure
REQ-023 Opcode constants, sel_dir encodings and the state enum SHALL live in a shared package, jof32_pkg.
REQ-024 One sub-module, redirect_target (pure-combinational target adder/sign-extender), SHALL be instantiated.
- All state, counter and squash logic stays in decode_redirect.

Verification
REQ-025 Straight line: pc_in 0x010..0x013, opcodes 6'h00 -> inst_id follows 1 cycle later, valid_id=1, sel_dir=00 throughout.
REQ-026 Jump: inst_id=0x0800_0123 at pc 0x020 -> same cycle sel_dir=01, pc_jump=0x123; next edge valid_id=0; following edge pc_id=0x123.
REQ-027 Branch taken, late:
- Stimulus: OP_BR, offset 0x3FE (-2) at pc 0x040; cond_valid after 3 cycles, cond_taken=1.
- Response: 3 replay cycles with pc_branch=0x041; then pc_branch=0x03E, flag_branch=1; one bubble.
REQ-028 Branch not-taken at pc 0x3FF -> pc_branch=0x000 (wrap), sel_dir=10, one bubble.
REQ-029 Timeout: OP_BR, cond_valid held 0 -> after 15 wait cycles, not-taken redirect to pc_id+1, err_timeout=1 and sticky.
REQ-030 Reset mid-WAIT_COND -> all outputs 0 immediately; after release, state RUN and normal capture.
